// File: rtl/module_display_7seg_scan.sv
// Time-multiplexed hex 7-segment driver: shadow-captured nibbles scanned round-robin onto shared active-low cathodes.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module module_display_7seg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_mask,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an
);

    localparam int DIV_W = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W = $clog2(N_DIGITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;

    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [7:0]            seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Digit select by explicit compare so idx width never has to match the vector index width.
    always_comb begin
        nib    = '0;
        dp_bit = 1'b0;
        blank  = 1'b0;
        an_nxt = '1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (int'(idx) == j) begin
                nib       = shadow_data[4*j +: 4];
                dp_bit    = shadow_dp[j];
                an_nxt[j] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (j > 0 && (shadow_data >> (4*j)) == '0)
                    blank = 1'b1;
`endif
            end
        end
        seg_nxt = {~dp_bit, blank ? 7'h7F : glyph(nib)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            div_cnt     <= '0;
            idx         <= '0;
            seg         <= 8'hFF;
            an          <= '1;
        end else begin
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp_mask;
            end
            if (en) begin
                seg <= seg_nxt;
                an  <= an_nxt;
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                idx     <= '0;
                seg     <= 8'hFF;
                an      <= '1;
            end
        end
    end

endmodule

// File: tb/tb_module_display_7seg_scan.sv
// Directed bench for module_display_7seg_scan with N_DIGITS=4, REFRESH_DIV=4.
// Blanking vectors run only when LEADING_ZERO_BLANK_EN is defined.
module tb_module_display_7seg_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [7:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] scan_seg [4] = '{8'hF9, 8'hF8, 8'h88, 8'hB0};
    logic [7:0] dp_seg [4]   = '{8'h79, 8'hF8, 8'h88, 8'hB0};
`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] blank5_seg [4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] blank0_seg [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`endif

    module_display_7seg_scan #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .data    (data),
        .dp_mask (dp_mask),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; dp_mask = '0;
        tick(); tick();
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_an", 32'(an), 32'hF);

        rst = 1'b0; en = 1'b1;
        tick();
        check("release_an", 32'(an), 32'hE);
        check("release_seg", 32'(seg), 32'hC0);

        en = 1'b0;
        tick();
        check("dark_seg", 32'(seg), 32'hFF);
        check("dark_an", 32'(an), 32'hF);

        // scan order with 3A71
        load = 1'b1; data = 16'h3A71; dp_mask = 4'b0000;
        tick();
        load = 1'b0; en = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("scan_an_d%0d_c%0d", d, c), 32'(an), 32'(an_tbl[d]));
                check($sformatf("scan_seg_d%0d_c%0d", d, c), 32'(seg), 32'(scan_seg[d]));
            end
        end
        tick();
        check("scan_wrap_an", 32'(an), 32'hE);
        check("scan_wrap_seg", 32'(seg), 32'hF9);

        // every glyph on digit 0
        for (int k = 0; k < 16; k++) begin
            en = 1'b0; load = 1'b1; data = 16'(k); dp_mask = 4'b0000;
            tick();
            en = 1'b1; load = 1'b0;
            tick();
            check($sformatf("glyph_%0h_an", k), 32'(an), 32'hE);
            check($sformatf("glyph_%0h_seg", k), 32'(seg), 32'({1'b1, glyph_tbl[k]}));
        end

        // decimal point on digit 0 only
        en = 1'b0; load = 1'b1; data = 16'h3A71; dp_mask = 4'b0001;
        tick();
        en = 1'b1; load = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("dp_an_c%0d", c), 32'(an), 32'(an_tbl[c/4]));
            check($sformatf("dp_seg_c%0d", c), 32'(seg), 32'(dp_seg[c/4]));
        end

        // disable mid digit 2, then restart with full dwell at digit 0
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        check("pre_disable_an", 32'(an), 32'hB);
        en = 1'b0;
        tick();
        check("disable_seg", 32'(seg), 32'hFF);
        check("disable_an", 32'(an), 32'hF);
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("resume_an_c%0d", c), 32'(an), 32'hE);
            check($sformatf("resume_seg_c%0d", c), 32'(seg), 32'h79);
        end
        tick();
        check("resume_next_an", 32'(an), 32'hD);
        check("resume_next_seg", 32'(seg), 32'hF8);

        // asynchronous reset mid-scan, no clock edge in between
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", 32'(seg), 32'hFF);
        check("async_rst_an", 32'(an), 32'hF);
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        tick();
        check("post_rst_an", 32'(an), 32'hE);
        check("post_rst_seg", 32'(seg), 32'hC0);

        // load coinciding with the wrap back to digit 0
        for (int c = 0; c < 14; c++) tick();
        load = 1'b1; data = 16'h0008; dp_mask = 4'b0000;
        tick();
        load = 1'b0;
        check("wrap_edge_an", 32'(an), 32'h7);
        check("wrap_edge_seg", 32'(seg), 32'hC0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("wrap_load_an_c%0d", c), 32'(an), 32'hE);
            check($sformatf("wrap_load_seg_c%0d", c), 32'(seg), 32'h80);
        end
        tick();
        check("wrap_next_an", 32'(an), 32'hD);
        check("wrap_next_seg", 32'(seg), 32'hC0);

`ifdef LEADING_ZERO_BLANK_EN
        en = 1'b0; load = 1'b1; data = 16'h0005; dp_mask = 4'b0000;
        tick();
        en = 1'b1; load = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("blank5_an_c%0d", c), 32'(an), 32'(an_tbl[c/4]));
            check($sformatf("blank5_seg_c%0d", c), 32'(seg), 32'(blank5_seg[c/4]));
        end
        en = 1'b0; load = 1'b1; data = 16'h0000;
        tick();
        en = 1'b1; load = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("blank0_an_c%0d", c), 32'(an), 32'(an_tbl[c/4]));
            check($sformatf("blank0_seg_c%0d", c), 32'(seg), 32'(blank0_seg[c/4]));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
